// File: rtl/picosoc_mem_ctrl_pkg.sv
// Shared types and constants for the picosoc_mem_ctrl slice.
//   state_e : controller FSM states (IDLE/ACC/RESP)
//   sel_e   : granted requester (SEL_CPU/SEL_LD)
//   SRAM_AW : SRAM word-address width
//   BURST_W : width of the loader fairness counter
package picosoc_mem_pkg;

  localparam int SRAM_AW = 22;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_LD  = 1'b1
  } sel_e;

endpackage

// File: rtl/picosoc_mem_arb.sv
// Grant selection between the CPU and loader ports plus the fairness counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   idle       : controller is in IDLE and may grant this cycle
//   mem_valid  : CPU request pending
//   ld_valid   : loader request pending
//   gnt        : a grant is made this cycle
//   gnt_sel    : which port wins (valid when gnt=1)
module picosoc_mem_arb
  import picosoc_mem_pkg::*;
#(
  parameter int LD_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic mem_valid,
  input  logic ld_valid,
  output logic gnt,
  output sel_e gnt_sel
);

  logic [BURST_W-1:0] streak_q, streak_d;
  logic               cpu_turn;

  always_comb begin
    // Loader normally wins; a waiting CPU gets one grant after LD_BURST loader grants.
    cpu_turn = mem_valid && (streak_q == BURST_W'(LD_BURST));
    gnt      = idle && (mem_valid || ld_valid);
    gnt_sel  = (ld_valid && !cpu_turn) ? SEL_LD : SEL_CPU;

    streak_d = streak_q;
    if (idle) begin
      if (!mem_valid || gnt_sel == SEL_CPU) begin
        streak_d = '0;
      end else begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/picosoc_mem_ctrl.sv
// Bus-side controller in front of the picosoc_mem SRAM. Arbitrates CPU and
// loader word requests, drives registered SRAM strobes and returns the SRAM's
// registered read data with a one-cycle ready pulse.
// Optional feature macro: PICOSOC_MEM_CTRL_BOUNDS_EN (address range check with
// sticky err_oob); when undefined, word addresses wrap modulo WORDS.
// Ports:
//   clk, rst                                   : clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb, mem_ready/rdata : CPU native memory port
//   ld_valid/addr/wdata/wstrb, ld_ready/rdata   : firmware-loader port
//   sram_wen/addr/wdata, sram_rdata             : SRAM strobes and read data
//   err_oob                                     : sticky out-of-range flag
module picosoc_mem_ctrl
  import picosoc_mem_pkg::*;
#(
  parameter int          WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LD_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  input  logic [31:0]        ld_wdata,
  input  logic [3:0]         ld_wstrb,
  output logic               ld_ready,
  output logic [31:0]        ld_rdata,
  output logic [3:0]         sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               err_oob
);

  state_e             state_q, state_d;
  sel_e               sel_q, sel_d;
  logic               wr_q, wr_d;
  logic               oob_q, oob_d;
  logic [3:0]         sram_wen_q, sram_wen_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]        sram_wdata_q, sram_wdata_d;

  logic               gnt;
  sel_e               gnt_sel;
  logic [31:0]        req_addr, req_wdata, req_off;
  logic [3:0]         req_wstrb;
  logic [SRAM_AW-1:0] req_word;
  logic               req_oob;
  logic               done;
  logic [31:0]        rdata_v;

  picosoc_mem_arb #(.LD_BURST(LD_BURST)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .idle      (state_q == IDLE),
    .mem_valid (mem_valid),
    .ld_valid  (ld_valid),
    .gnt       (gnt),
    .gnt_sel   (gnt_sel)
  );

  always_comb begin
    req_addr  = (gnt_sel == SEL_LD) ? ld_addr  : mem_addr;
    req_wdata = (gnt_sel == SEL_LD) ? ld_wdata : mem_wdata;
    req_wstrb = (gnt_sel == SEL_LD) ? ld_wstrb : mem_wstrb;
    req_off   = req_addr - BASE_ADDR;
`ifdef PICOSOC_MEM_CTRL_BOUNDS_EN
    // Checking addr < BASE first keeps the offset compare free of wraparound.
    req_oob   = (req_addr < BASE_ADDR) || (req_off >= 32'(4 * WORDS));
    req_word  = SRAM_AW'(req_off >> 2);
`else
    req_oob   = 1'b0;
    req_word  = SRAM_AW'(req_off >> 2) & SRAM_AW'(WORDS - 1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    oob_d        = oob_q;
    sram_wen_d   = sram_wen_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          sel_d        = gnt_sel;
          // Out-of-range writes take the read path so ready lands at T+2.
          wr_d         = (req_wstrb != 4'b0) && !req_oob;
          oob_d        = req_oob;
          sram_addr_d  = req_word;
          sram_wdata_d = req_wdata;
          sram_wen_d   = req_oob ? 4'b0 : req_wstrb;
          state_d      = ACC;
        end
      end
      ACC: begin
        sram_wen_d = 4'b0;
        state_d    = wr_q ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= SEL_CPU;
      wr_q         <= 1'b0;
      oob_q        <= 1'b0;
      sram_wen_q   <= 4'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      oob_q        <= oob_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

`ifdef PICOSOC_MEM_CTRL_BOUNDS_EN
  logic err_oob_q, err_oob_d;

  always_comb begin
    err_oob_d = err_oob_q | ((state_q == IDLE) && gnt && req_oob);
  end

  always_ff @(posedge clk) begin
    if (rst) err_oob_q <= 1'b0;
    else     err_oob_q <= err_oob_d;
  end

  assign err_oob = err_oob_q;
`else
  assign err_oob = 1'b0;
`endif

  // Ready is gated by rst so a reset in ACC or RESP swallows the pulse.
  always_comb begin
    done      = !rst && (((state_q == ACC) && wr_q) || (state_q == RESP));
    mem_ready = done && (sel_q == SEL_CPU);
    ld_ready  = done && (sel_q == SEL_LD);
    rdata_v   = oob_q ? 32'h0 : sram_rdata;
    mem_rdata = mem_ready ? rdata_v : 32'h0;
    ld_rdata  = ld_ready  ? rdata_v : 32'h0;
  end

  assign sram_wen   = sram_wen_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
module tb_picosoc_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, ld_valid;
  logic [31:0] mem_addr, mem_wdata, ld_addr, ld_wdata;
  logic [3:0]  mem_wstrb, ld_wstrb;
  logic        mem_ready, ld_ready;
  logic [31:0] mem_rdata, ld_rdata;
  logic [3:0]  sram_wen;
  logic [21:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picosoc_mem_ctrl #(
    .WORDS(256), .BASE_ADDR(32'h0), .LD_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_wstrb(ld_wstrb), .ld_ready(ld_ready), .ld_rdata(ld_rdata),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .err_oob(err_oob)
  );

  // Behavioural SRAM: byte writes and registered read, both at the clock edge.
  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (sram_wen[i]) sram[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
    sram_rdata <= sram[sram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request (caller is just after a rising edge); returns ready latency
  // in cycles from the grant cycle (-1 on timeout), read data and wen activity.
  task automatic do_req(input bit ld, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output int lat, output logic [31:0] rdata,
                        output int wen_cycles, output logic [3:0] wen_seen);
    lat = -1; rdata = 32'h0; wen_cycles = 0; wen_seen = 4'h0;
    if (ld) begin
      ld_valid = 1'b1; ld_addr = addr; ld_wdata = wdata; ld_wstrb = wstrb;
    end else begin
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sram_wen != 4'h0) begin
        wen_cycles++;
        wen_seen = sram_wen;
      end
      if (ld ? ld_ready : mem_ready) begin
        lat = k;
        rdata = ld ? ld_rdata : mem_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  int          lat, wcyc, n, cyc;
  logic [31:0] rd, cpu_rd;
  logic [3:0]  wseen;
  int          ev [6];
  int          exp_ev [6];
  logic        both;

  initial begin
    exp_ev = '{1, 1, 1, 1, 2, 1};
    rst = 1'b1;
    mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    ld_valid = 0; ld_addr = 0; ld_wdata = 0; ld_wstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_ld_rdata", ld_rdata, 32'h0);
    chk("rst_sram_wen", {28'h0, sram_wen}, 32'h0);
    chk("rst_sram_addr", {10'h0, sram_addr}, 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    chk("rst_err_oob", {31'h0, err_oob}, 32'h0);
    @(posedge clk); #1;

    // Preload through the loader port.
    do_req(1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, lat, rd, wcyc, wseen);
    chk("ld_wr_lat", lat, 1);
    chk("ld_wr_wen", {28'h0, wseen}, 32'hF);
    do_req(1'b1, 32'h8, 32'h1122_3344, 4'hF, lat, rd, wcyc, wseen);
    chk("ld_wr2_lat", lat, 1);

    // CPU read of word 5.
    do_req(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("cpu_rd_lat", lat, 2);
    chk("cpu_rd_data", rd, 32'hCAFE_F00D);
    chk("cpu_rd_no_wen", wcyc, 0);

    // CPU byte write to byte 2 of word 2.
    do_req(1'b0, 32'h8, 32'h00AB_0000, 4'b0100, lat, rd, wcyc, wseen);
    chk("cpu_bw_lat", lat, 1);
    chk("cpu_bw_wen_cycles", wcyc, 1);
    chk("cpu_bw_wen", {28'h0, wseen}, 32'h4);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("cpu_bw_readback", rd, 32'h11AB_3344);

    // Contention: both ports hold read requests.
    ld_valid = 1'b1; ld_addr = 32'h14; ld_wstrb = 4'h0;
    mem_valid = 1'b1; mem_addr = 32'h8; mem_wstrb = 4'h0;
    n = 0; cyc = 0; both = 1'b0; cpu_rd = 32'h0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_ready && ld_ready) both = 1'b1;
      if (ld_ready) begin
        ev[n] = 1; n++;
      end else if (mem_ready) begin
        ev[n] = 2; n++; cpu_rd = mem_rdata;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; ld_valid = 1'b0;
    chk("cont_events", n, 6);
    chk("cont_both_ready", {31'h0, both}, 32'h0);
    for (int i = 0; i < 6; i++) chk($sformatf("cont_ev%0d", i), ev[i], exp_ev[i]);
    chk("cont_cpu_rdata", cpu_rd, 32'h11AB_3344);
    repeat (3) @(posedge clk); #1;

    // Reset asserted in the ACC cycle of a CPU write.
    mem_valid = 1'b1; mem_addr = 32'hC; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
    @(negedge clk);
    chk("rstw_rdy_grant", {31'h0, mem_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstw_rdy_acc", {31'h0, mem_ready}, 32'h0);
    chk("rstw_wen_acc", {28'h0, sram_wen}, 32'hF);
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("rstw_post_ready", {31'h0, mem_ready | ld_ready}, 32'h0);
    chk("rstw_post_wen", {28'h0, sram_wen}, 32'h0);
    chk("rstw_post_addr", {10'h0, sram_addr}, 32'h0);
    chk("rstw_post_wdata", sram_wdata, 32'h0);
    chk("rstw_post_rdata", mem_rdata | ld_rdata, 32'h0);
    @(posedge clk); #1;
    do_req(1'b1, 32'hC, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("rstw_readback", rd, 32'hDEAD_BEEF);

    // Write just past the window (word 256).
    do_req(1'b1, 32'h0, 32'h0, 4'hF, lat, rd, wcyc, wseen);
    do_req(1'b0, 32'h400, 32'h5555_AAAA, 4'hF, lat, rd, wcyc, wseen);
`ifdef PICOSOC_MEM_CTRL_BOUNDS_EN
    chk("oob_wr_lat", lat, 2);
    chk("oob_wr_wen", wcyc, 0);
    chk("oob_err", {31'h0, err_oob}, 32'h1);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("oob_rd_lat", lat, 2);
    chk("oob_rd_data", rd, 32'h0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("oob_word0", rd, 32'h0);
    chk("oob_err_sticky", {31'h0, err_oob}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("oob_err_cleared", {31'h0, err_oob}, 32'h0);
`else
    chk("wrap_wr_lat", lat, 1);
    chk("wrap_wr_wen", wcyc, 1);
    chk("wrap_err", {31'h0, err_oob}, 32'h0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, wcyc, wseen);
    chk("wrap_word0", rd, 32'h5555_AAAA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/picosoc_mem_ctrl.md
# picosoc_mem_ctrl

Bus-side controller sitting directly upstream of the `picosoc_mem` SRAM. It accepts word requests from the PicoRV32 native memory port and from a host firmware-loader port, and arbitrates between them. Granted requests are converted into registered SRAM strobes, and the SRAM's one-cycle read data is returned with a single-cycle ready pulse. The loader has priority, but a bounded-burst rule keeps the CPU from starving.

## Interface
Parameters:
- `WORDS`, 256: SRAM depth in 32-bit words; must match the SRAM instance.
- `BASE_ADDR`, 32'h0000_0000: byte base address of the SRAM window.
- `LD_BURST`, 4: maximum consecutive loader grants while a CPU request waits (1..15).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  CPU request valid; held high until `mem_ready`.
- `mem_addr`  in  32  CPU byte address.
- `mem_wdata`  in  32  CPU write data.
- `mem_wstrb`  in  4  CPU byte strobes; 0 means read.
- `mem_ready`  out  1  CPU completion pulse.
- `mem_rdata`  out  32  CPU read data, valid while `mem_ready`=1.
- `ld_valid`, `ld_addr`[31:0], `ld_wdata`[31:0], `ld_wstrb`[3:0], `ld_ready`, `ld_rdata`[31:0]: loader port, same semantics as the CPU port.
- `sram_wen`  out  4  byte write enables to the SRAM.
- `sram_addr`  out  22  word address to the SRAM.
- `sram_wdata`  out  32  write data to the SRAM.
- `sram_rdata`  in  32  SRAM registered read data.
- `err_oob`  out  1  sticky out-of-range flag (see Configuration).

## Operation
- FSM states: IDLE, ACC, RESP.
- IDLE:
  - Grant selection: when `ld_valid`=1, the loader wins, unless `mem_valid`=1 and `streak`==`LD_BURST`, in which case the CPU wins. When only the CPU is valid, the CPU wins.
  - On a grant, register the port select, `sram_addr` = (addr−BASE_ADDR)[23:2], `sram_wdata`, and `sram_wen` = wstrb. Go to ACC.
- ACC:
  - Clear `sram_wen` to 0.
  - Write: pulse the granted port's ready and return to IDLE.
  - Read: go to RESP.
- RESP: pulse the granted port's ready, with rdata = `sram_rdata`, then return to IDLE.
- Fairness counter `streak` (4 bits):
  - Increments on each loader grant made while `mem_valid`=1.
  - Clears on a CPU grant, or on any IDLE cycle with `mem_valid`=0.
- Read data:
  - Drive `mem_rdata`/`ld_rdata` with `sram_rdata` only while the corresponding ready is high; otherwise drive 0.
  - The non-granted port's ready stays 0.

## Timing
- Reset values: state IDLE, `sram_wen`=0, `sram_addr`=0, `sram_wdata`=0, `streak`=0, `err_oob`=0. `mem_ready` and `ld_ready` are 0 and `mem_rdata` and `ld_rdata` are 0.
- Grant at cycle T (IDLE with valid). The SRAM samples its strobes at the edge ending T+1.
- Write ready is asserted in T+1. Read ready is asserted in T+2.
- Next grant is possible at T+2 after a write and at T+3 after a read, provided valid is still or again high.
- Ready is always exactly one cycle wide. A requester holding valid after ready starts a new transaction.
- Simultaneous valids: arbitration as above. The losing request stays pending with no side effects.
- Reset asserted during ACC: a write already registered completes in the SRAM at that edge, because the SRAM samples the old `sram_wen`. No ready is issued and state returns to IDLE.
- Reset asserted during RESP: ready is suppressed in that cycle.

## Configuration
- Macro: `PICOSOC_MEM_CTRL_BOUNDS_EN`.
- Defined:
  - A request with addr < BASE_ADDR or addr ≥ BASE_ADDR+4·WORDS still follows IDLE→ACC→RESP, so ready arrives at T+2 for both reads and writes.
  - `sram_wen` stays 0 and rdata is 0.
  - `err_oob` sets and holds until `rst`.
- Undefined:
  - No range check; the word address wraps modulo `WORDS` (power of two required).
  - `err_oob` is tied to 0.

## Structure
- Package `picosoc_mem_pkg` holds:
  - the state enum (IDLE/ACC/RESP);
  - the port-select enum (SEL_CPU/SEL_LD);
  - `SRAM_AW`=22;
  - `BURST_W`=4.
- Sub-module `picosoc_mem_arb` is combinational grant selection plus the `streak` register. The FSM and datapath stay in the top module.

## Test plan
- CPU read, no loader: preload word 5 = 32'hCAFE_F00D. `mem_addr`=0x14 → `mem_ready` at T+2 with `mem_rdata`=32'hCAFE_F00D and `sram_wen` never nonzero.
- CPU byte write: `mem_wstrb`=4'b0100, `mem_wdata`=32'h00AB_0000 to 0x8 → `sram_wen`=4'b0100 for exactly one cycle (T+1) and `mem_ready` at T+1. A read of 0x8 then returns byte2 = 0xAB with the other bytes unchanged.
- Contention:
  - Stimulus: `ld_valid` and `mem_valid` held high, `LD_BURST`=4, all requests reads.
  - Response: 4 loader readies, then 1 CPU ready, then the loader resumes.
- Reset mid-write: assert `rst` in the ACC cycle of a write → the SRAM word holds the new data, no ready pulses, and all outputs are at their reset values the following cycle.
- With `PICOSOC_MEM_CTRL_BOUNDS_EN`, `WORDS`=256, write to 0x400 → `mem_ready` at T+2, `sram_wen`=0 throughout, `err_oob`=1 and staying 1 until `rst`. Without the macro, the same write lands at word 0.
